// File: rtl/uart_tx_switch_if.sv
// Serial-line bundle between the two UART transmitters, the TXD selector and the pad.
// The slave side is the selector; the master side drives the requests and the serial inputs.
interface uart_tx_switch_if;
  logic sel_ocd1_cpu0;
  logic tx_cpu;
  logic tx_ocd;
  logic TXD;
  logic active_ocd1_cpu0;
  logic switch_pending;
  logic forced_switch;

  modport slave (
    input  sel_ocd1_cpu0,
    input  tx_cpu,
    input  tx_ocd,
    output TXD,
    output active_ocd1_cpu0,
    output switch_pending,
    output forced_switch
  );

  modport master (
    output sel_ocd1_cpu0,
    output tx_cpu,
    output tx_ocd,
    input  TXD,
    input  active_ocd1_cpu0,
    input  switch_pending,
    input  forced_switch
  );
endinterface

// File: rtl/uart_tx_switch.sv
// Frame-safe 2:1 TXD selector (CPU vs OCD UART). It switches only after both lines
// have been idle for a full frame, or it forces the switch once a drain timeout expires.
module uart_tx_switch #(
  parameter int BAUD_PERIOD    = 104,
  parameter int IDLE_BITS      = 10,
  parameter int TIMEOUT_FRAMES = 16
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_switch_if.slave   bus
);

  localparam int N       = IDLE_BITS * BAUD_PERIOD;
  localparam int IDLE_W  = $clog2(N + 1);
  localparam int FRAME_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam int PRE_W   = $clog2(N);

  localparam logic [IDLE_W-1:0]  IDLE_LAST   = IDLE_W'(N - 1);
  localparam logic [PRE_W-1:0]   PRE_LAST    = PRE_W'(N - 1);
  localparam logic [FRAME_W-1:0] FRAME_LIMIT = FRAME_W'(TIMEOUT_FRAMES);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [IDLE_W-1:0]   r_idle_cnt;
  logic [IDLE_W-1:0]   w_idle_next;
  logic [FRAME_W-1:0]  r_frame_cnt;
  logic [FRAME_W-1:0]  w_frame_next;
  logic [PRE_W-1:0]    r_prescaler;
  logic [PRE_W-1:0]    w_pre_next;
  logic                r_active;
  logic                w_active_next;
  logic                r_forced;
  logic                w_forced_next;
  logic                r_pending;
  logic                r_txd;
  logic                w_both_idle;
  logic                w_sel_differs;

  assign w_both_idle   = bus.tx_cpu & bus.tx_ocd;
  assign w_sel_differs = bus.sel_ocd1_cpu0 ^ r_active;

  // Next-state logic: the abort path wins over the normal switch, and the normal switch wins over the timeout.
  always_comb begin
    w_state_next  = r_state;
    w_idle_next   = {IDLE_W{1'b0}};
    w_frame_next  = {FRAME_W{1'b0}};
    w_pre_next    = {PRE_W{1'b0}};
    w_active_next = r_active;
    w_forced_next = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_sel_differs) begin
          w_state_next = S_DRAIN;
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_DRAIN: begin
        if (!w_sel_differs) begin
          w_state_next = S_RUN;
        end else if (w_both_idle && (r_idle_cnt == IDLE_LAST)) begin
          w_state_next  = S_RUN;
          w_active_next = ~r_active;
        end else if (r_frame_cnt == FRAME_LIMIT) begin
          w_state_next  = S_RUN;
          w_active_next = ~r_active;
          w_forced_next = 1'b1;
        end else begin
          w_state_next = S_DRAIN;
          w_idle_next  = w_both_idle ? (r_idle_cnt + IDLE_W'(1)) : {IDLE_W{1'b0}};
          if (r_prescaler == PRE_LAST) begin
            w_pre_next   = {PRE_W{1'b0}};
            w_frame_next = r_frame_cnt + FRAME_W'(1);
          end else begin
            w_pre_next   = r_prescaler + PRE_W'(1);
            w_frame_next = r_frame_cnt;
          end
        end
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase
  end

  // State, counters and registered outputs; TXD always samples the source that is active this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_idle_cnt  <= {IDLE_W{1'b0}};
      r_frame_cnt <= {FRAME_W{1'b0}};
      r_prescaler <= {PRE_W{1'b0}};
      r_active    <= 1'b0;
      r_forced    <= 1'b0;
      r_pending   <= 1'b0;
      r_txd       <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_idle_cnt  <= w_idle_next;
      r_frame_cnt <= w_frame_next;
      r_prescaler <= w_pre_next;
      r_active    <= w_active_next;
      r_forced    <= w_forced_next;
      r_pending   <= (w_state_next == S_DRAIN);
      r_txd       <= r_active ? bus.tx_ocd : bus.tx_cpu;
    end
  end

  assign bus.TXD              = r_txd;
  assign bus.active_ocd1_cpu0 = r_active;
  assign bus.switch_pending   = r_pending;
  assign bus.forced_switch    = r_forced;

endmodule
